// File: rtl/level_sequencer.sv
// level_sequencer: frame-paced game-flow FSM for the slingshot game (load, aim, flight, settle, level/game outcome)
//
// Ports:
//   clk                 system clock
//   resetN              asynchronous active-low reset
//   startOfFrame        one-cycle pulse at each frame start
//   start_key           one-cycle pulse, start/restart game (IDLE, GAME_WON, GAME_OVER only)
//   launch_key          one-cycle pulse, release bird (AIM only)
//   bird_stopped        bird left the screen or came to rest (FLIGHT only)
//   pigs_left[3:0]      live pig count from the level
//   collision_bird_pig  bird-pig overlap this pixel
//   current_level[3:0]  0-based level index
//   birds_left[2:0]     birds not yet launched in this level
//   state[2:0]          IDLE=0 LOAD=1 AIM=2 FLIGHT=3 SETTLE=4 LEVEL_WON=5 GAME_WON=6 GAME_OVER=7
//   load_level          one-cycle pulse on the first LOAD cycle
//   bird_reset          hold bird on slingshot (low only in AIM/FLIGHT)
//   launch_enable       launch permitted (AIM)
//   level_won, game_won, game_over  status flags
//   score[15:0]         player score
//
// Build option: LEVEL_SEQ_SCORE_EN enables scoring; without it score is tied to 0.
module level_sequencer #(
  parameter int NUM_LEVELS      = 3,
  parameter int BIRDS_PER_LEVEL = 3,
  parameter int LOAD_FRAMES     = 2,
  parameter int SETTLE_FRAMES   = 30,
  parameter int BANNER_FRAMES   = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        launch_key,
  input  logic        bird_stopped,
  input  logic [3:0]  pigs_left,
  input  logic        collision_bird_pig,
  output logic [3:0]  current_level,
  output logic [2:0]  birds_left,
  output logic [2:0]  state,
  output logic        load_level,
  output logic        bird_reset,
  output logic        launch_enable,
  output logic        level_won,
  output logic        game_won,
  output logic        game_over,
  output logic [15:0] score
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    AIM       = 3'd2,
    FLIGHT    = 3'd3,
    SETTLE    = 3'd4,
    LEVEL_WON = 3'd5,
    GAME_WON  = 3'd6,
    GAME_OVER = 3'd7
  } state_e;

  localparam logic [7:0] LOAD_LAST   = 8'(LOAD_FRAMES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES - 1);
  localparam logic [7:0] BANNER_LAST = 8'(BANNER_FRAMES - 1);
  localparam logic [3:0] LAST_LEVEL  = 4'(NUM_LEVELS - 1);
  localparam logic [2:0] BIRDS_INIT  = 3'(BIRDS_PER_LEVEL);

  state_e      state_q, state_d;
  logic [7:0]  frame_q;
  logic        entry_q;
  logic [3:0]  level_q, level_d;
  logic [2:0]  birds_q, birds_d;
  logic        frame_tick, frame_done, new_game, entering;
  logic [7:0]  frame_last;

  // The entry cycle's frame pulse is deliberately not counted.
  assign frame_tick = startOfFrame && !entry_q;
  assign frame_last = (state_q == LOAD) ? LOAD_LAST : (state_q == SETTLE) ? SETTLE_LAST : BANNER_LAST;
  assign frame_done = frame_tick && (frame_q == frame_last);
  assign new_game   = start_key && (state_q == IDLE || state_q == GAME_WON || state_q == GAME_OVER);

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    birds_d = birds_q;
    case (state_q)
      IDLE, GAME_WON, GAME_OVER: begin
        if (start_key) begin
          state_d = LOAD;
          level_d = '0;
        end
      end
      LOAD:   state_d = frame_done ? AIM : LOAD;
      AIM: begin
        if (launch_key) begin
          state_d = FLIGHT;
          birds_d = birds_q - 3'd1;
        end
      end
      FLIGHT: state_d = bird_stopped ? SETTLE : FLIGHT;
      SETTLE: begin
        if (frame_done)
          state_d = (pigs_left == 4'd0) ? LEVEL_WON : (birds_q == 3'd0) ? GAME_OVER : AIM;
      end
      LEVEL_WON: begin
        if (frame_done) begin
          state_d = (level_q == LAST_LEVEL) ? GAME_WON : LOAD;
          level_d = (level_q == LAST_LEVEL) ? level_q : level_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_d == LOAD && state_q != LOAD) birds_d = BIRDS_INIT;
  end

  assign entering = (state_d != state_q);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      entry_q       <= 1'b0;
      level_q       <= '0;
      birds_q       <= '0;
      load_level    <= 1'b0;
      bird_reset    <= 1'b1;
      launch_enable <= 1'b0;
      level_won     <= 1'b0;
      game_won      <= 1'b0;
      game_over     <= 1'b0;
    end else begin
      state_q       <= state_d;
      level_q       <= level_d;
      birds_q       <= birds_d;
      entry_q       <= entering;
      frame_q       <= entering ? 8'd0 : frame_tick ? frame_q + 8'd1 : frame_q;
      load_level    <= entering && (state_d == LOAD);
      bird_reset    <= !(state_d == AIM || state_d == FLIGHT);
      launch_enable <= (state_d == AIM);
      level_won     <= (state_d == LEVEL_WON);
      game_won      <= (state_d == GAME_WON);
      game_over     <= (state_d == GAME_OVER);
    end
  end

  assign state         = state_q;
  assign current_level = level_q;
  assign birds_left    = birds_q;

`ifdef LEVEL_SEQ_SCORE_EN
  logic [15:0] score_q;
  logic        armed_q;
  logic        hit, won_entry;
  logic [17:0] sum;

  // One hit award per frame; a frame pulse re-arms in the same cycle it arrives.
  assign hit       = collision_bird_pig && (armed_q || startOfFrame) && (state_q == FLIGHT || state_q == SETTLE);
  assign won_entry = (state_d == LEVEL_WON) && (state_q != LEVEL_WON);
  assign sum       = 18'(score_q) + (hit ? 18'd10 : 18'd0) + (won_entry ? 18'(birds_q) * 18'd100 : 18'd0);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      score_q <= '0;
      armed_q <= 1'b1;
    end else begin
      score_q <= new_game ? 16'd0 : (sum > 18'h0FFFF) ? 16'hFFFF : sum[15:0];
      armed_q <= hit ? 1'b0 : startOfFrame ? 1'b1 : armed_q;
    end
  end

  assign score = score_q;
`else
  logic unused_score_inputs;
  assign unused_score_inputs = collision_bird_pig ^ new_game;
  assign score = '0;
`endif
endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: directed and randomized game play checked against a shot-level game model
module tb_level_sequencer;
  localparam int NL = 2, BPL = 2, LF = 2, SF = 3, BF = 4;

  logic        clk = 1'b0, resetN = 1'b0;
  logic        sof = 1'b0, start_key = 1'b0, launch_key = 1'b0, bird_stopped = 1'b0, coll = 1'b0;
  logic [3:0]  pigs_left = 4'd3;
  logic [3:0]  current_level;
  logic [2:0]  birds_left, state;
  logic        load_level, bird_reset, launch_enable, level_won, game_won, game_over;
  logic [15:0] score;

  int checks = 0, failures = 0;
  int m_lvl = 0, m_birds = 0, m_score = 0, se = 0, r = 0;

  level_sequencer #(
    .NUM_LEVELS(NL), .BIRDS_PER_LEVEL(BPL), .LOAD_FRAMES(LF), .SETTLE_FRAMES(SF), .BANNER_FRAMES(BF)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(sof), .start_key(start_key), .launch_key(launch_key),
    .bird_stopped(bird_stopped), .pigs_left(pigs_left), .collision_bird_pig(coll),
    .current_level(current_level), .birds_left(birds_left), .state(state), .load_level(load_level),
    .bird_reset(bird_reset), .launch_enable(launch_enable), .level_won(level_won),
    .game_won(game_won), .game_over(game_over), .score(score)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string t, input int s);
    chk({t, ".state"}, 32'(state), s);
    chk({t, ".level"}, 32'(current_level), m_lvl);
    chk({t, ".birds"}, 32'(birds_left), m_birds);
    chk({t, ".bird_reset"}, 32'(bird_reset), (s == 2 || s == 3) ? 0 : 1);
    chk({t, ".launch_en"}, 32'(launch_enable), (s == 2) ? 1 : 0);
    chk({t, ".level_won"}, 32'(level_won), (s == 5) ? 1 : 0);
    chk({t, ".game_won"}, 32'(game_won), (s == 6) ? 1 : 0);
    chk({t, ".game_over"}, 32'(game_over), (s == 7) ? 1 : 0);
    chk({t, ".score"}, 32'(score), se ? m_score : 0);
  endtask

  // A frame pulse preceded by at least one idle cycle, so it never lands on an entry cycle.
  task automatic frame;
    repeat (1 + $urandom_range(0, 2)) tick();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) frame();
  endtask

  task automatic start_game;
    start_key = 1'b1;
    tick();
    start_key = 1'b0;
    m_lvl = 0; m_score = 0; m_birds = BPL;
    chk_all("start", 1);
    chk("start.load_pulse", 32'(load_level), 1);
  endtask

  task automatic load;
    frames(LF - 1);
    chk_all("loading", 1);
    frame();
    chk_all("aim", 2);
  endtask

  // One launch-flight-settle cycle; the outcome follows the game rules on the model.
  task automatic shot(input logic [3:0] p, input int nseg, input int clen, output int res);
    launch_key = 1'b1;
    tick();
    launch_key = 1'b0;
    m_birds--;
    chk_all("launch", 3);
    repeat (nseg) begin
      coll = 1'b1;
      repeat (clen) tick();
      coll = 1'b0;
      m_score = sat(m_score + 10);
      frame();
    end
    chk_all("fly", 3);
    pigs_left = p;
    bird_stopped = 1'b1;
    tick();
    bird_stopped = 1'b0;
    chk_all("stop", 4);
    frames(SF - 1);
    chk_all("settling", 4);
    frame();
    if (p == 4'd0) begin
      m_score = sat(m_score + 100 * m_birds);
      res = 5;
    end else res = (m_birds == 0) ? 7 : 2;
    chk_all("judge", res);
  endtask

  task automatic banner(output int res);
    frames(BF - 1);
    chk_all("banner", 5);
    frame();
    if (m_lvl == NL - 1) begin
      res = 6;
      chk_all("game_won", 6);
    end else begin
      m_lvl++;
      m_birds = BPL;
      res = 1;
      chk_all("next_level", 1);
      chk("next.load_pulse", 32'(load_level), 1);
    end
  endtask

  task automatic play_game;
    int res;
    logic [3:0] p;
    start_game();
    res = 1;
    while (res == 1) begin
      load();
      res = 2;
      while (res == 2) begin
        p = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        shot(p, $urandom_range(0, 2), $urandom_range(1, 5), res);
      end
      if (res == 5) banner(res);
    end
  endtask

  initial begin
`ifdef LEVEL_SEQ_SCORE_EN
    se = 1;
`endif
    repeat (3) tick();
    chk_all("reset", 0);
    chk("reset.load", 32'(load_level), 0);
    resetN = 1'b1;
    tick();

    start_game();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    chk("load.width", 32'(load_level), 0);
    chk("load.entry_sof", 32'(state), 1);
    frame();
    chk("load.one_frame", 32'(state), 1);
    frame();
    chk_all("first_aim", 2);
    start_key = 1'b1;
    bird_stopped = 1'b1;
    tick();
    start_key = 1'b0;
    bird_stopped = 1'b0;
    chk_all("aim.ignore", 2);

    shot(4'd0, 1, 5, r);
    banner(r);
    load();
    shot(4'd0, 0, 1, r);
    banner(r);
    launch_key = 1'b1;
    bird_stopped = 1'b1;
    tick();
    launch_key = 1'b0;
    bird_stopped = 1'b0;
    chk_all("won.hold", 6);

    start_game();
    load();
    shot(4'd2, 0, 1, r);
    shot(4'd2, 1, 2, r);
    chk("lose.result", 32'(r), 7);
    tick();
    chk_all("over.hold", 7);

    start_game();
    load();
    shot(4'd2, 0, 1, r);
    shot(4'd0, 0, 1, r);
    chk("tie.result", 32'(r), 5);
    banner(r);
    load();
    launch_key = 1'b1;
    tick();
    launch_key = 1'b0;
    m_birds--;
    chk_all("pre_reset", 3);
    #2 resetN = 1'b0;
    #1;
    m_lvl = 0; m_birds = 0; m_score = 0;
    chk_all("async_reset", 0);
    chk("async_reset.load", 32'(load_level), 0);
    @(negedge clk) resetN = 1'b1;
    tick();
    chk_all("after_reset", 0);

    repeat (10) play_game();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/level_sequencer.md
# level_sequencer

Frame-paced game-flow controller for the slingshot game. It sequences level loading, bird aiming, flight and settling, and counts birds per level. It advances the level when all pigs are cleared and declares game won or game over. It sits between the collision/game-control logic (pig count, bird-pig hits) and the level ROM, bird motion and HUD blocks, which it drives.

## Interface
- NUM_LEVELS, 3: number of levels, 1..15
- BIRDS_PER_LEVEL, 3: birds granted at each level load, 1..7
- LOAD_FRAMES, 2: frames spent in LOAD before aiming
- SETTLE_FRAMES, 30: frames waited after the bird stops, before judging the shot
- BANNER_FRAMES, 60: frames the level-won banner is shown
---
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at each frame start (30 Hz)
- start_key  in  1  one-cycle pulse, start/restart game
- launch_key  in  1  one-cycle pulse, release bird from slingshot
- bird_stopped  in  1  level; bird left the screen or came to rest
- pigs_left  in  4  live pig count from the level
- collision_bird_pig  in  1  level; bird-pig overlap this pixel
- current_level  out  4  level index, 0-based
- birds_left  out  3  birds not yet launched in this level
- state  out  3  encoded FSM state
- load_level  out  1  one-cycle pulse: level ROM loads current_level
- bird_reset  out  1  hold bird on slingshot
- launch_enable  out  1  launch permitted
- level_won, game_won, game_over  out  1 each  status flags
- score  out  16  player score

## Operation
- State encoding: IDLE=0, LOAD=1, AIM=2, FLIGHT=3, SETTLE=4, LEVEL_WON=5, GAME_WON=6, GAME_OVER=7.
- IDLE:
  - start_key → LOAD, with current_level←0 and score←0.
- LOAD:
  - load_level pulses on the first cycle in LOAD.
  - birds_left←BIRDS_PER_LEVEL.
  - After LOAD_FRAMES startOfFrame pulses → AIM.
- AIM:
  - launch_enable=1.
  - launch_key → FLIGHT, with birds_left decremented.
- FLIGHT:
  - bird_stopped=1 → SETTLE.
- SETTLE:
  - After SETTLE_FRAMES pulses, the first matching rule applies, in this order:
    - pigs_left==0 → LEVEL_WON.
    - birds_left==0 → GAME_OVER.
    - Otherwise → AIM.
- LEVEL_WON:
  - After BANNER_FRAMES pulses: if current_level==NUM_LEVELS-1 → GAME_WON; otherwise current_level+1 and → LOAD.
- GAME_WON / GAME_OVER:
  - Held until start_key, then → LOAD, with current_level←0 and score←0.
- Output decode:
  - bird_reset=0 only in AIM and FLIGHT.
  - level_won=1 only in LEVEL_WON.
  - game_won and game_over=1 only in their own states.
  - launch_enable=1 only in AIM.
- Ignored inputs:
  - start_key outside IDLE, GAME_WON and GAME_OVER.
  - launch_key outside AIM.
  - bird_stopped outside FLIGHT.
- Simultaneous events:
  - If pigs_left==0 and birds_left==0 at SETTLE end, LEVEL_WON wins.
- Frame counter:
  - 8-bit, cleared on every state entry.
  - Increments on startOfFrame.
  - Transition happens on the edge of the Nth pulse counted in the state.
  - A startOfFrame on the entry cycle itself is not counted.

## Timing
- All outputs are registered.
- A state change is visible on the cycle after the qualifying input or pulse.
- load_level is exactly 1 cycle wide, in the first cycle state==LOAD.
- Reset values (asynchronous, immediate, valid mid-operation):
  - state=IDLE, current_level=0, birds_left=0, score=0.
  - load_level=0, launch_enable=0, all flags 0, bird_reset=1.
- birds_left never underflows: launch is only possible in AIM, and every entry to AIM has birds_left≥1.

## Configuration
- LEVEL_SEQ_SCORE_EN defined:
  - +10 for the first cycle of collision_bird_pig in each frame, counted only in FLIGHT or SETTLE. The frame flag is re-armed by startOfFrame.
  - +100·birds_left on the cycle the FSM enters LEVEL_WON.
  - Score saturates at 0xFFFF.
- LEVEL_SEQ_SCORE_EN undefined:
  - score is tied to 0.
  - No scoring logic is synthesized.

## Test plan
All scenarios use NUM_LEVELS=2, BIRDS_PER_LEVEL=2, LOAD_FRAMES=2, SETTLE_FRAMES=3, BANNER_FRAMES=4.
- **Reset and start:** reset, then start_key → state=1 and load_level a single 1-cycle pulse. After 2 startOfFrame pulses → state=2, birds_left=2, launch_enable=1, bird_reset=0.
- **Win level 0 on first shot:** launch_key then bird_stopped with pigs_left=0; after 3 frames → state=5, level_won=1. After 4 frames → state=1, current_level=1.
- **Lose:** at level 0 with pigs_left=2, take two shots, each with a settle → state=7, game_over=1, birds_left=0. Then start_key → state=1, current_level=0.
- **Clear last level:** with current_level=1, shot clears pigs; after banner → state=6, game_won=1. launch_key is ignored there.
- **Tie-break and reset:** pigs_left=0 together with birds_left=0 at settle → state=5. Assert resetN low in FLIGHT → state=0 at once, all outputs at reset values.
- **Score, with LEVEL_SEQ_SCORE_EN:** collision held 5 cycles within one frame → score=10. Clear the level with 1 bird left → score=110.
